// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings and sequencer state type for the AHB-to-AHB bridge.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERR1,
        S_ERR2
    } seq_state_e;

endpackage

// File: rtl/ahb_bridge_seq_if.sv
// Bus-A slave port and bus-B master port of the bridge sequencer.
// The slave modport is the bridge's view; master is the surrounding system.
interface ahb_bridge_seq_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          HSEL_s;
    logic [1:0]    HTRANS_s;
    logic [AW-1:0] HADDR_s;
    logic          HWRITE_s;
    logic [2:0]    HSIZE_s;
    logic [DW-1:0] HWDATA_s;
    logic          HREADY_s;
    logic          HREADYOUT_s;
    logic [1:0]    HRESP_s;
    logic [DW-1:0] HRDATA_s;

    logic          HBUSREQ_m;
    logic          HGRANT_m;
    logic          HREADY_m;
    logic [1:0]    HRESP_m;
    logic [1:0]    HTRANS_m;
    logic [AW-1:0] HADDR_m;
    logic          HWRITE_m;
    logic [2:0]    HSIZE_m;
    logic [DW-1:0] HWDATA_m;
    logic [DW-1:0] HRDATA_m;

    modport slave (
        input  HSEL_s, HTRANS_s, HADDR_s, HWRITE_s, HSIZE_s, HWDATA_s, HREADY_s,
               HGRANT_m, HREADY_m, HRESP_m, HRDATA_m,
        output HREADYOUT_s, HRESP_s, HRDATA_s,
               HBUSREQ_m, HTRANS_m, HADDR_m, HWRITE_m, HSIZE_m, HWDATA_m
    );

    modport master (
        output HSEL_s, HTRANS_s, HADDR_s, HWRITE_s, HSIZE_s, HWDATA_s, HREADY_s,
               HGRANT_m, HREADY_m, HRESP_m, HRDATA_m,
        input  HREADYOUT_s, HRESP_s, HRDATA_s,
               HBUSREQ_m, HTRANS_m, HADDR_m, HWRITE_m, HSIZE_m, HWDATA_m
    );

endinterface

// File: rtl/ahb_grant_timer.sv
// Counts cycles spent waiting for bus-B grant; expires on the GNT_TO-th cycle.
module ahb_grant_timer #(
    parameter int unsigned GNT_TO = 255
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned W = $clog2(GNT_TO + 1);
    localparam logic [W-1:0] LAST = W'(GNT_TO - 1);

    logic [W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_bridge_seq.sv
// Bridge sequencer: stalls one bus-A transfer, replays it as bus-B master,
// then returns read data or a two-cycle ERROR to bus A.
module ahb_bridge_seq
    import ahb_bridge_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned GNT_TO = 255
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb_bridge_seq_if.slave bus
);
    seq_state_e    r_state, w_state_nxt;
    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [2:0]    r_size;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_wcap;

    logic w_accept;
    logic w_take;
    logic w_expire;

    assign w_accept = bus.HSEL_s && bus.HREADY_s &&
                      (bus.HTRANS_s == HTRANS_NONSEQ || bus.HTRANS_s == HTRANS_SEQ);
    assign w_take   = w_accept && (r_state == S_IDLE || r_state == S_DONE);

    ahb_grant_timer #(.GNT_TO(GNT_TO)) u_timer (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .i_clear  (r_state != S_REQ),
        .i_en     (r_state == S_REQ),
        .o_expire (w_expire)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wcap  <= 1'b0;
        end else begin
            if (w_take) begin
                r_addr  <= bus.HADDR_s;
                r_write <= bus.HWRITE_s;
                r_size  <= bus.HSIZE_s;
                r_wcap  <= 1'b1;
            end
            // Bus-A write data arrives in the cycle after accept; a replay keeps it.
            if (r_state == S_REQ && r_wcap) begin
                r_wdata <= bus.HWDATA_s;
                r_wcap  <= 1'b0;
            end
            if (r_state == S_DATA && bus.HREADY_m && bus.HRESP_m == HRESP_OKAY && !r_write) begin
                r_rdata <= bus.HRDATA_m;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        bus.HREADYOUT_s = 1'b1;
        bus.HRESP_s     = HRESP_OKAY;
        bus.HRDATA_s    = r_rdata;
        bus.HBUSREQ_m   = 1'b0;
        bus.HTRANS_m    = HTRANS_IDLE;
        bus.HADDR_m     = '0;
        bus.HWRITE_m    = 1'b0;
        bus.HSIZE_m     = '0;
        bus.HWDATA_m    = '0;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = w_take ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                bus.HREADYOUT_s = 1'b0;
                bus.HBUSREQ_m   = 1'b1;
                if (bus.HGRANT_m && bus.HREADY_m) w_state_nxt = S_ADDR;
                else if (w_expire)                 w_state_nxt = S_ERR1;
            end
            S_ADDR: begin
                bus.HREADYOUT_s = 1'b0;
                bus.HTRANS_m    = HTRANS_NONSEQ;
                bus.HADDR_m     = r_addr;
                bus.HWRITE_m    = r_write;
                bus.HSIZE_m     = r_size;
                if (bus.HREADY_m) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                bus.HREADYOUT_s = 1'b0;
                bus.HWDATA_m    = r_wdata;
                if (bus.HREADY_m) begin
                    unique case (bus.HRESP_m)
                        HRESP_OKAY:  w_state_nxt = S_DONE;
                        HRESP_ERROR: w_state_nxt = S_ERR1;
                        default:     w_state_nxt = S_REQ;
                    endcase
                end
            end
            S_ERR1: begin
                bus.HREADYOUT_s = 1'b0;
                bus.HRESP_s     = HRESP_ERROR;
                w_state_nxt     = S_ERR2;
            end
            S_ERR2: begin
                bus.HRESP_s = HRESP_ERROR;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
